// File: rtl/store_buffer.sv
// Post-commit store buffer: a DEPTH-entry FIFO of committed stores that drains
// to the data SRAM over req/ack and forwards bytes to execute-stage loads.
module store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MERGE  = 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         st_valid,
    output logic                         st_ready,
    input  logic [ADDR_W-1:0]            st_addr,
    input  logic [DATA_W/8-1:0]          st_wstrb,
    input  logic [DATA_W-1:0]            st_wdata,
    input  logic [ADDR_W-1:0]            ld_addr,
    output logic [DATA_W/8-1:0]          ld_fwd_bmask,
    output logic [DATA_W-1:0]            ld_fwd_data,
    output logic                         mem_req,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W/8-1:0]          mem_wstrb,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_ack,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(NB - 1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [NB-1:0]     strb_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ADDR_W-1:0] st_word;
    logic [ADDR_W-1:0] ld_word;
    logic [PTR_W-1:0]  young;
    logic              merge_hit;
    logic              push;
    logic              push_new;
    logic              pop;
    logic [PTR_W-1:0]  fwd_idx;

    assign st_word = st_addr & WORD_MASK;
    assign ld_word = ld_addr & WORD_MASK;
    assign young   = tail_q - PTR_W'(1);

    // count>=2 guarantees the youngest entry is not the head, which the SRAM may be sampling
    assign merge_hit = (MERGE != 0) && (count_q >= CNT_W'(2)) && (addr_q[young] == st_word);
    assign st_ready  = (count_q < CNT_W'(DEPTH)) || merge_hit;
    assign push      = st_valid && st_ready;
    assign push_new  = push && !merge_hit;
    assign pop       = mem_ack && (count_q != '0);

    assign mem_req   = (count_q != '0);
    assign mem_addr  = addr_q[head_q];
    assign mem_wstrb = strb_q[head_q];
    assign mem_wdata = data_q[head_q];
    assign count     = count_q;
    assign empty     = (count_q == '0);

    // Pointer and occupancy next state
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_new) tail_d = tail_q + PTR_W'(1);
        if (pop)      head_d = head_q + PTR_W'(1);
        if (push_new && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push_new && pop) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage: new stores go to tail, merges go to the youngest entry
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i] <= '0;
                strb_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (push_new) begin
            addr_q[tail_q] <= st_word;
            strb_q[tail_q] <= st_wstrb;
            data_q[tail_q] <= st_wdata;
        end else if (push) begin
            strb_q[young] <= strb_q[young] | st_wstrb;
            for (int b = 0; b < int'(NB); b++) begin
                if (st_wstrb[b]) data_q[young][b*8 +: 8] <= st_wdata[b*8 +: 8];
            end
        end
    end

    // Walk oldest to youngest so later matches override earlier ones per lane
    always_comb begin
        ld_fwd_bmask = '0;
        ld_fwd_data  = '0;
        fwd_idx      = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_q[fwd_idx] == ld_word)) begin
                for (int b = 0; b < int'(NB); b++) begin
                    if (strb_q[fwd_idx][b]) begin
                        ld_fwd_bmask[b]        = 1'b1;
                        ld_fwd_data[b*8 +: 8]  = data_q[fwd_idx][b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: one coalescing instance and one non-coalescing
// instance share stimulus; expectations are hand-computed constants.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] ld_addr;
    logic        mem_ack;

    logic        st_ready,  nm_st_ready;
    logic [3:0]  fwd_bmask, nm_fwd_bmask;
    logic [31:0] fwd_data,  nm_fwd_data;
    logic        mem_req,   nm_mem_req;
    logic [31:0] mem_addr,  nm_mem_addr;
    logic [3:0]  mem_wstrb, nm_mem_wstrb;
    logic [31:0] mem_wdata, nm_mem_wdata;
    logic [2:0]  count,     nm_count;
    logic        empty,     nm_empty;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .MERGE(1)) u_dut (
        .clk(clk), .resetn(resetn),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_wstrb(st_wstrb), .st_wdata(st_wdata),
        .ld_addr(ld_addr), .ld_fwd_bmask(fwd_bmask), .ld_fwd_data(fwd_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .count(count), .empty(empty)
    );

    store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .MERGE(0)) u_dut_nm (
        .clk(clk), .resetn(resetn),
        .st_valid(st_valid), .st_ready(nm_st_ready), .st_addr(st_addr),
        .st_wstrb(st_wstrb), .st_wdata(st_wdata),
        .ld_addr(ld_addr), .ld_fwd_bmask(nm_fwd_bmask), .ld_fwd_data(nm_fwd_data),
        .mem_req(nm_mem_req), .mem_addr(nm_mem_addr), .mem_wstrb(nm_mem_wstrb),
        .mem_wdata(nm_mem_wdata), .mem_ack(mem_ack),
        .count(nm_count), .empty(nm_empty)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change at posedge+1; outputs are read after a further #1
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_wstrb = s;
        st_wdata = d;
        step();
        st_valid = 1'b0;
        #1;
    endtask

    task automatic ack();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        step();
    endtask

    logic [31:0] held_addr, held_data;
    logic [3:0]  held_strb;
    int          sent, popped, cyc;

    initial begin
        resetn   = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_wstrb = '0;
        st_wdata = '0;
        ld_addr  = '0;
        mem_ack  = 1'b0;
        step();
        step();
        check("rst_mem_req",  64'(mem_req), 64'd0);
        check("rst_count",    64'(count), 64'd0);
        check("rst_empty",    64'(empty), 64'd1);
        check("rst_st_ready", 64'(st_ready), 64'd1);
        check("rst_bmask",    64'(fwd_bmask), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        #2 resetn = 1'b1;
        step();

        // Asynchronous reset mid-cycle with three pending entries
        push(32'h10, 4'hF, 32'h1111_1111);
        push(32'h20, 4'hF, 32'h2222_2222);
        push(32'h30, 4'hF, 32'h3333_3333);
        check("pre_rst_count", 64'(count), 64'd3);
        check("pre_rst_req",   64'(mem_req), 64'd1);
        ld_addr = 32'h20;
        #1;
        resetn = 1'b0;
        #1;
        check("arst_mem_req",  64'(mem_req), 64'd0);
        check("arst_count",    64'(count), 64'd0);
        check("arst_empty",    64'(empty), 64'd1);
        check("arst_st_ready", 64'(st_ready), 64'd1);
        check("arst_bmask",    64'(fwd_bmask), 64'd0);
        step();
        #1 resetn = 1'b1;
        step();
        check("rel_mem_req", 64'(mem_req), 64'd0);
        push(32'h200, 4'hF, 32'h1234_5678);
        check("rel_mem_addr", 64'(mem_addr), 64'h200);
        check("rel_mem_req2", 64'(mem_req), 64'd1);
        check("rel_count",    64'(count), 64'd1);

        // Byte-lane coalescing versus plain queueing
        do_reset();
        push(32'h100, 4'b0011, 32'h0000_AAAA);
        push(32'h100, 4'b0110, 32'h00BB_BB00);
        push(32'h100, 4'b1000, 32'hCC00_0000);
        ld_addr = 32'h102;
        #1;
        check("mrg_count",    64'(count), 64'd2);
        check("mrg_bmask",    64'(fwd_bmask), 64'hF);
        check("mrg_fwd_data", 64'(fwd_data), 64'hCCBB_BBAA);
        check("nm_count",     64'(nm_count), 64'd3);
        check("nm_bmask",     64'(nm_fwd_bmask), 64'hF);
        check("nm_fwd_data",  64'(nm_fwd_data), 64'hCCBB_BBAA);
        check("nm_strb0",     64'(nm_mem_wstrb), 64'b0011);
        ld_addr = 32'h104;
        #1;
        check("miss_bmask", 64'(fwd_bmask), 64'd0);
        check("miss_data",  64'(fwd_data), 64'd0);
        ack();
        check("mrg_ack_count", 64'(count), 64'd1);
        check("mrg_ack_strb",  64'(mem_wstrb), 64'b1110);
        check("mrg_ack_data",  64'(mem_wdata), 64'hCCBB_BB00);
        check("nm_strb1",      64'(nm_mem_wstrb), 64'b0110);
        ack();
        check("mrg_empty",     64'(empty), 64'd1);
        check("nm_strb2",      64'(nm_mem_wstrb), 64'b1000);
        ack();
        check("nm_empty",      64'(nm_empty), 64'd1);
        check("mrg_idle_ack",  64'(count), 64'd0);

        // Full buffer: merge still accepted, non-merge refused despite same-cycle ack
        do_reset();
        push(32'h10, 4'hF, 32'h1111_1111);
        push(32'h20, 4'hF, 32'h2222_2222);
        push(32'h30, 4'hF, 32'h3333_3333);
        push(32'h40, 4'hF, 32'h4444_4444);
        st_addr = 32'h50;
        #1;
        check("full_count", 64'(count), 64'd4);
        check("full_ready", 64'(st_ready), 64'd0);
        st_addr = 32'h41;
        #1;
        check("full_merge_ready", 64'(st_ready), 64'd1);
        push(32'h41, 4'b0001, 32'h0000_00EE);
        ld_addr = 32'h40;
        #1;
        check("full_merge_count", 64'(count), 64'd4);
        check("full_merge_data",  64'(fwd_data), 64'h4444_44EE);
        st_valid = 1'b1;
        st_addr  = 32'h50;
        st_wstrb = 4'hF;
        st_wdata = 32'h5555_5555;
        mem_ack  = 1'b1;
        #1;
        check("full_ack_ready", 64'(st_ready), 64'd0);
        step();
        st_valid = 1'b0;
        mem_ack  = 1'b0;
        #1;
        check("full_after_count", 64'(count), 64'd3);
        check("full_after_head",  64'(mem_addr), 64'h20);
        check("full_after_ready", 64'(st_ready), 64'd1);
        ld_addr = 32'h50;
        #1;
        check("full_rejected_fwd", 64'(fwd_bmask), 64'd0);

        // Wrap-around with random ack gaps
        do_reset();
        sent   = 0;
        popped = 0;
        cyc    = 0;
        while ((popped < 12) && (cyc < 300)) begin
            st_valid = (sent < 12);
            st_addr  = 32'(sent * 4);
            st_wstrb = 4'hF;
            st_wdata = 32'(sent);
            mem_ack  = 1'($urandom_range(0, 1));
            #1;
            if (mem_req && mem_ack) begin
                check("wrap_addr", 64'(mem_addr), 64'(popped * 4));
                popped++;
            end
            if (st_valid && st_ready) sent++;
            check("wrap_count_max", 64'(count <= 3'd4), 64'd1);
            step();
            cyc++;
        end
        st_valid = 1'b0;
        mem_ack  = 1'b0;
        #1;
        check("wrap_popped", 64'(popped), 64'd12);
        check("wrap_empty",  64'(empty), 64'd1);

        // Ack while empty is ignored; head holds stable across stalls
        do_reset();
        ack();
        repeat (5) step();
        check("idle_count", 64'(count), 64'd0);
        check("idle_req",   64'(mem_req), 64'd0);
        push(32'h83, 4'b0101, 32'h0055_0055);
        check("ack_addr", 64'(mem_addr), 64'h80);
        check("ack_strb", 64'(mem_wstrb), 64'b0101);
        check("ack_data", 64'(mem_wdata), 64'h0055_0055);
        held_addr = mem_addr;
        held_strb = mem_wstrb;
        held_data = mem_wdata;
        push(32'h86, 4'hF, 32'hDEAD_BEEF);
        for (int k = 0; k < 3; k++) begin
            check("stall_addr", 64'(mem_addr), 64'(held_addr));
            check("stall_strb", 64'(mem_wstrb), 64'(held_strb));
            check("stall_data", 64'(mem_wdata), 64'(held_data));
            step();
        end
        ack();
        check("next_addr",  64'(mem_addr), 64'h84);
        check("next_data",  64'(mem_wdata), 64'hDEAD_BEEF);
        check("next_count", 64'(count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
